// File: rtl/cpu_common_pkg.sv
// Constants and types shared by the CPU sound path: the tone generator FSM state
// and the clock rate that software frequency formulas are derived from.
package cpu_common;

  localparam int unsigned SND_COUNT_WIDTH = 26;
  localparam int unsigned SND_CLK_HZ      = 50_000_000;

  typedef enum logic {
    SND_SILENT  = 1'b0,
    SND_RUNNING = 1'b1
  } snd_state_t;

endpackage

// File: rtl/snd_tone_gen.sv
// Square-wave tone generator: toggles snd_out every active_count clk cycles.
// New counts are applied at a half-period boundary (or at once when DEFER_UPDATE=0).
module snd_tone_gen
  import cpu_common::*;
#(
  parameter int unsigned COUNT_WIDTH  = SND_COUNT_WIDTH,
  parameter bit          DEFER_UPDATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_async,
  input  logic [COUNT_WIDTH-1:0] snd_max_count,
  input  logic                   snd_latch_max_count,
  output logic                   snd_out,
  output logic                   snd_active,
  output logic                   snd_update_pending
);

  snd_state_t             state;
  logic [COUNT_WIDTH-1:0] active_count;
  logic [COUNT_WIDTH-1:0] pending_count;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   terminal_c;
  logic                   go_silent_c;

  // RUNNING guarantees active_count >= 1, so the subtraction never wraps.
  assign terminal_c  = (cnt == active_count - COUNT_WIDTH'(1));
  assign go_silent_c = terminal_c && snd_update_pending && (pending_count == '0);

  // Counter, FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state              <= SND_SILENT;
      active_count       <= '0;
      pending_count      <= '0;
      cnt                <= '0;
      snd_out            <= 1'b0;
      snd_active         <= 1'b0;
      snd_update_pending <= 1'b0;
    end else begin
      case (state)
        SND_SILENT: begin
          snd_out <= 1'b0;
          cnt     <= '0;
          if (snd_latch_max_count && (snd_max_count != '0)) begin
            active_count <= snd_max_count;
            state        <= SND_RUNNING;
            snd_active   <= 1'b1;
          end
        end

        SND_RUNNING: begin
          if (!DEFER_UPDATE && snd_latch_max_count) begin
            // Immediate mode: restart the half-period with the new count, level unchanged.
            cnt <= '0;
            if (snd_max_count == '0) begin
              state      <= SND_SILENT;
              snd_out    <= 1'b0;
              snd_active <= 1'b0;
            end else begin
              active_count <= snd_max_count;
            end
          end else begin
            if (terminal_c) begin
              cnt <= '0;
              if (snd_update_pending) begin
                snd_update_pending <= 1'b0;
                active_count       <= pending_count;
              end
              if (go_silent_c) begin
                state      <= SND_SILENT;
                snd_out    <= 1'b0;
                snd_active <= 1'b0;
              end else begin
                snd_out <= ~snd_out;
              end
            end else begin
              cnt <= cnt + COUNT_WIDTH'(1);
            end
            // A latch on a terminal edge queues behind the count applied there.
            if (DEFER_UPDATE && snd_latch_max_count && !go_silent_c) begin
              pending_count      <= snd_max_count;
              snd_update_pending <= 1'b1;
            end
          end
        end

        default: state <= SND_SILENT;
      endcase
    end
  end

endmodule
